// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch and decode sequencer.
//
// Fetches 9-bit instruction words from an instruction memory at address p,
// which is supplied by the register file. Words are decoded into
// register-file control fields. mov takes two words: an opcode word and
// then an operand word. Execution stops on HALT_OP and stays stopped until
// start is raised again.
//
// Ports
//   clk         in   rising-edge clock
//   start       in   synchronous active-high reset; its falling edge starts a run
//   p           in   [9:0] current PC from the register file
//   imem_addr   out  [9:0] instruction-memory read address (always equals p)
//   imem_data   in   [8:0] instruction word, valid IMEM_LAT cycles after the address
//   pc_hold     out  register file must not advance PC this cycle
//   instr_valid out  decoded fields are an instruction to execute this cycle
//   reg_op      out  [4:0] register-file operation code
//   reg_src     out  [3:0] source register index
//   reg_dst     out  [3:0] destination register index
//   instr_o     out  [3:0] operand field
//   alu_en      out  ALU result write-back enable
//   movp        out  mov targets the PC
//   done        out  program halted
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | held in reset or waiting for the first edge with start low
// FETCH     | waiting IMEM_LAT cycles for an opcode word, then latch it in IR
// ISSUE     | present the decoded opcode word for one cycle
// FETCH2    | waiting IMEM_LAT cycles for the mov operand word
// ISSUE_MOV | present the mov with the source/destination taken from IR
// HALT      | stopped; done held high until start

module fetch_decode #(
  parameter int         IMEM_LAT = 1,
  parameter logic [4:0] HALT_OP  = 5'd1
) (
  input  logic       clk,
  input  logic       start,
  input  logic [9:0] p,
  output logic [9:0] imem_addr,
  input  logic [8:0] imem_data,
  output logic       pc_hold,
  output logic       instr_valid,
  output logic [4:0] reg_op,
  output logic [3:0] reg_src,
  output logic [3:0] reg_dst,
  output logic [3:0] instr_o,
  output logic       alu_en,
  output logic       movp,
  output logic       done
);

  localparam logic [4:0] OP_MOV   = 5'd6;
  // Counter value loaded on entry to a fetch state. The fetch ends on the
  // cycle where the counter reads zero.
  localparam logic [1:0] LAT_LAST = 2'(IMEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_FETCH2    = 3'd3,
    S_ISSUE_MOV = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t     state, state_next;
  logic [1:0] lat_cnt, lat_cnt_next;
  logic [8:0] ir;
  logic       ir_load;

  // Last issued field values. Outside an issue cycle they are shown on the
  // outputs unchanged.
  logic [4:0] op_q, op_next;
  logic [3:0] src_q, src_next;
  logic [3:0] dst_q, dst_next;
  logic [3:0] io_q, io_next;

  logic [4:0] opcode;
  logic [3:0] operand;
  logic       reserved;

  assign opcode    = ir[8:4];
  assign operand   = ir[3:0];
  assign imem_addr = p;

  always_comb begin
    reserved = 1'b0;
    case (opcode)
      5'd0, 5'd2, 5'd3, 5'd7, 5'd16, 5'd18, 5'd19: reserved = 1'b1;
      default:                                     reserved = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state   <= S_IDLE;
      lat_cnt <= 2'd0;
      ir      <= 9'd0;
      op_q    <= 5'd0;
      src_q   <= 4'd0;
      dst_q   <= 4'd0;
      io_q    <= 4'd0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
      if (ir_load) ir <= imem_data;
      op_q    <= op_next;
      src_q   <= src_next;
      dst_q   <= dst_next;
      io_q    <= io_next;
    end
  end

  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    ir_load      = 1'b0;
    pc_hold      = 1'b1;
    instr_valid  = 1'b0;
    alu_en       = 1'b0;
    movp         = 1'b0;
    done         = 1'b0;
    op_next      = op_q;
    src_next     = src_q;
    dst_next     = dst_q;
    io_next      = io_q;

    case (state)
      S_IDLE: begin
        state_next   = S_FETCH;
        lat_cnt_next = LAT_LAST;
      end

      S_FETCH, S_FETCH2: begin
        if (lat_cnt == 2'd0) begin
          ir_load    = 1'b1;
          state_next = (state == S_FETCH) ? S_ISSUE : S_ISSUE_MOV;
        end else begin
          lat_cnt_next = lat_cnt - 2'd1;
        end
      end

      S_ISSUE: begin
        lat_cnt_next = LAT_LAST;
        // Halt is tested first so a HALT_OP value that collides with mov
        // or a reserved code still stops the program.
        if (opcode == HALT_OP) begin
          state_next = S_HALT;
        end else if (opcode == OP_MOV) begin
          // Let PC step onto the operand word. Nothing issues yet.
          pc_hold    = 1'b0;
          state_next = S_FETCH2;
        end else begin
          pc_hold    = 1'b0;
          state_next = S_FETCH;
          if (!reserved) begin
            instr_valid = 1'b1;
            op_next     = opcode;
            io_next     = operand;
            if (opcode[4:3] == 2'b01) begin
              src_next = operand;
              dst_next = operand;
            end
            alu_en = (opcode[4:2] == 3'b111);
          end
        end
      end

      S_ISSUE_MOV: begin
        pc_hold      = 1'b0;
        state_next   = S_FETCH;
        lat_cnt_next = LAT_LAST;
        // An operand word with bit 8 set is illegal. It is dropped, but PC
        // still moves past it.
        if (!ir[8]) begin
          instr_valid = 1'b1;
          op_next     = OP_MOV;
          src_next    = ir[7:4];
          dst_next    = ir[3:0];
          movp        = (ir[3:0] == 4'hf);
        end
      end

      S_HALT: begin
        done = 1'b1;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // During an issue cycle the new field values go straight to the outputs.
  // In every other cycle the registered copies are shown.
  assign reg_op  = op_next;
  assign reg_src = src_next;
  assign reg_dst = dst_next;
  assign instr_o = io_next;

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: two fetch_decode instances, with IMEM_LAT=1 and
// IMEM_LAT=2, driven one at a time. The bench plays the register file,
// owning p, and the instruction memory. A transaction-level model walks the
// program one instruction at a time and predicts every cycle's outputs.

module tb_fetch_decode;

  localparam logic [4:0] HOP = 5'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       start_v [2];
  logic [9:0] p_v     [2];

  logic [8:0] mem [1024];
  logic [8:0] mem_q;

  logic [9:0] ad0, ad1;
  logic [8:0] dat0, dat1;
  logic       h0, v0, a0, m0, d0;
  logic       h1, v1, a1, m1, d1;
  logic [4:0] op0, op1;
  logic [3:0] s0, t0, i0, s1, t1, i1;

  fetch_decode #(.IMEM_LAT(1), .HALT_OP(HOP)) u_lat1 (
    .clk(clk), .start(start_v[0]), .p(p_v[0]), .imem_addr(ad0), .imem_data(dat0),
    .pc_hold(h0), .instr_valid(v0), .reg_op(op0), .reg_src(s0), .reg_dst(t0),
    .instr_o(i0), .alu_en(a0), .movp(m0), .done(d0));

  fetch_decode #(.IMEM_LAT(2), .HALT_OP(HOP)) u_lat2 (
    .clk(clk), .start(start_v[1]), .p(p_v[1]), .imem_addr(ad1), .imem_data(dat1),
    .pc_hold(h1), .instr_valid(v1), .reg_op(op1), .reg_src(s1), .reg_dst(t1),
    .instr_o(i1), .alu_en(a1), .movp(m1), .done(d1));

  // Latency-1 memory answers within the cycle. The latency-2 memory
  // registers the address, so the first fetch cycle still sees the old word.
  assign dat0 = mem[ad0];
  always @(posedge clk) mem_q <= mem[ad1];
  assign dat1 = mem_q;

  int total = 0;
  int bad   = 0;

  // Last issued field values, as the model sees them.
  logic [4:0] h_op;
  logic [3:0] h_src, h_dst, h_io;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (done,hold,valid,alu,movp,op,src,dst,io,addr)", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int k);
    if (k == 0) return {d0, h0, v0, a0, m0, op0, s0, t0, i0, ad0};
    return {d1, h1, v1, a1, m1, op1, s1, t1, i1, ad1};
  endfunction

  function automatic logic [31:0] ev(input logic dn, input logic hd, input logic vl,
                                     input logic al, input logic mp, input logic [9:0] addr);
    return {dn, hd, vl, al, mp, h_op, h_src, h_dst, h_io, addr};
  endfunction

  function automatic bit is_reserved(input logic [4:0] op);
    return op inside {5'd0, 5'd2, 5'd3, 5'd7, 5'd16, 5'd18, 5'd19};
  endfunction

  task automatic clear_model();
    h_op = 5'd0; h_src = 4'd0; h_dst = 4'd0; h_io = 4'd0;
  endtask

  // Inputs are set at posedge+1. Outputs are compared at the negedge.
  task automatic step(input int k, input string tag, input logic [31:0] e);
    @(negedge clk);
    check(tag, obs(k), e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_hold(input int k, input int n);
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    repeat (n) step(k, "reset", ev(0, 1, 0, 0, 0, p_v[k]));
  endtask

  task automatic release_run(input int k, input logic [9:0] newp);
    start_v[k] = 1'b0;
    p_v[k]     = newp;
    step(k, "idle", ev(0, 1, 0, 0, 0, p_v[k]));
  endtask

  task automatic fetch_phase(input int k, input string tag);
    repeat (k + 1) step(k, tag, ev(0, 1, 0, 0, 0, p_v[k]));
  endtask

  // Runs one instruction starting at the current p.
  task automatic exec_one(input int k, input bit allow_jump, output bit halted);
    logic [8:0] w, w2;
    logic [4:0] op;
    w  = mem[p_v[k]];
    op = w[8:4];
    halted = 1'b0;
    fetch_phase(k, "fetch");
    if (op == HOP) begin
      step(k, "halt_issue", ev(0, 1, 0, 0, 0, p_v[k]));
      halted = 1'b1;
    end else if (op == 5'd6) begin
      step(k, "mov_first", ev(0, 0, 0, 0, 0, p_v[k]));
      p_v[k] = p_v[k] + 10'd1;
      w2 = mem[p_v[k]];
      fetch_phase(k, "fetch2");
      if (w2[8]) begin
        step(k, "mov_illegal", ev(0, 0, 0, 0, 0, p_v[k]));
      end else begin
        h_op = 5'd6; h_src = w2[7:4]; h_dst = w2[3:0];
        step(k, "mov_issue", ev(0, 0, 1, 0, w2[3:0] == 4'hf, p_v[k]));
      end
      p_v[k] = p_v[k] + 10'd1;
    end else if (is_reserved(op)) begin
      step(k, "nop", ev(0, 0, 0, 0, 0, p_v[k]));
      p_v[k] = p_v[k] + 10'd1;
    end else begin
      h_op = op; h_io = w[3:0];
      if (op >= 5'd8 && op <= 5'd15) begin
        h_src = w[3:0]; h_dst = w[3:0];
      end
      step(k, "issue", ev(0, 0, 1, op >= 5'd28, 0, p_v[k]));
      // A taken branch loads a new p on the issue edge.
      if (allow_jump && $urandom_range(0, 7) == 0) p_v[k] = 10'($urandom);
      else                                         p_v[k] = p_v[k] + 10'd1;
    end
  endtask

  task automatic halt_seq(input int k);
    repeat (20) step(k, "halted", ev(1, 1, 0, 0, 0, p_v[k]));
    start_v[k] = 1'b1;
    step(k, "halt_last", ev(1, 1, 0, 0, 0, p_v[k]));
    clear_model();
    step(k, "halt_cleared", ev(0, 1, 0, 0, 0, p_v[k]));
  endtask

  task automatic run_instance(input int k);
    bit halted;
    reset_hold(k, 3);

    // A small program: ALU-class op, mov to PC, alu op, reserved op, halt at p=5.
    mem[0] = 9'h0A3; mem[1] = 9'h060; mem[2] = 9'h06F;
    mem[3] = 9'h1C5; mem[4] = 9'h020; mem[5] = 9'h010;
    release_run(k, 10'd0);
    for (int i = 0; i < 6; i++) begin
      exec_one(k, 1'b0, halted);
      if (halted) break;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
    check("halt_pc", {22'd0, p_v[k]}, 32'd5);
    halt_seq(k);

    // Reset arriving in FETCH2 aborts the mov.
    mem[10'h100] = 9'h060; mem[10'h101] = 9'h032;
    mem[10'h200] = 9'h005; mem[10'h201] = 9'h060; mem[10'h202] = 9'h101;
    release_run(k, 10'h100);
    fetch_phase(k, "fetch");
    step(k, "mov_first", ev(0, 0, 0, 0, 0, p_v[k]));
    p_v[k] = p_v[k] + 10'd1;
    start_v[k] = 1'b1;
    step(k, "fetch2_abort", ev(0, 1, 0, 0, 0, p_v[k]));
    clear_model();
    step(k, "abort_reset", ev(0, 1, 0, 0, 0, p_v[k]));
    release_run(k, 10'h200);
    exec_one(k, 1'b0, halted);
    exec_one(k, 1'b0, halted);
    check("after_illegal_pc", {22'd0, p_v[k]}, 32'h203);

    // Random program with random branches. A halt restarts at a random p.
    reset_hold(k, 1);
    for (int a = 0; a < 1024; a++) mem[a] = 9'($urandom);
    release_run(k, 10'($urandom));
    for (int n = 0; n < 300; n++) begin
      exec_one(k, 1'b1, halted);
      if (halted) begin
        halt_seq(k);
        release_run(k, 10'($urandom));
      end
    end
    reset_hold(k, 2);
  endtask

  initial begin
    start_v[0] = 1'b1; start_v[1] = 1'b1;
    p_v[0] = 10'd0;    p_v[1] = 10'd0;
    clear_model();
    for (int a = 0; a < 1024; a++) mem[a] = 9'd0;
    @(posedge clk);
    #1;
    run_instance(0);
    run_instance(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 The module SHALL have parameter IMEM_LAT, default 1, meaning instruction-memory read latency in cycles (legal values 1 or 2).
REQ-002 The module SHALL have parameter HALT_OP, default 5'd1, meaning the opcode that stops execution.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port start, input, 1: synchronous active-high reset; while high the block is held in reset; its falling edge begins a program run.
REQ-005 Port p, input, 10: current program counter from the register file.
REQ-006 Port imem_addr, output, 10: instruction-memory read address.
REQ-007 Port imem_data, input, 9: instruction word, valid IMEM_LAT cycles after the address is presented.
REQ-008 Port pc_hold, output, 1: when high, the register file does not advance PC.
REQ-009 Port instr_valid, output, 1: the decoded fields are an instruction to execute this cycle.
REQ-010 Port reg_op, output, 5: register-file operation code (reg_OP encoding).
REQ-011 Port reg_src / reg_dst, output, 4 each: register indices.
REQ-012 Port instr_o, output, 4: operand field.
REQ-013 Port alu_en, output, 1: ALU result write-back enable.
REQ-014 Port movp, output, 1: move into PC.
REQ-015 Port done, output, 1: program halted.

Function
REQ-016 Word format: opcode = word[8:4], operand = word[3:0]; mov (opcode 6) is two words, with the second word laid out as {0, src[3:0], dst[3:0]}.
REQ-017 imem_addr SHALL equal p combinationally in every state.
REQ-018 FSM states: IDLE, FETCH, ISSUE, FETCH2, ISSUE_MOV, HALT.
REQ-019 IDLE: entered on any edge with start=1; pc_hold=1; goes to FETCH on the first edge with start=0.
REQ-020 FETCH / FETCH2: pc_hold=1 and instr_valid=0; a latency counter counts IMEM_LAT cycles; on the final cycle the IR (9-bit) captures imem_data, then the FSM goes to ISSUE or ISSUE_MOV respectively.
REQ-021 ISSUE for a non-mov, non-halt opcode: instr_valid=1, pc_hold=0 for exactly one cycle, with reg_op=opcode and instr_o=word[3:0]; next state FETCH.
REQ-022 In ISSUE, reg_src=reg_dst=word[3:0] for opcodes 8-15.
REQ-023 In ISSUE, alu_en=1 for opcodes 28-31; otherwise alu_en=0.
REQ-024 ISSUE for mov: instr_valid=0, pc_hold=0 (advances PC to the operand word); next state FETCH2.
REQ-025 ISSUE_MOV: instr_valid=1, pc_hold=0, reg_op=6, reg_src=IR[7:4], reg_dst=IR[3:0], movp=(IR[3:0]==4'hf); next state FETCH.
REQ-026 A mov operand word with IR[8]=1 SHALL be issued with instr_valid=0 (illegal encoding, dropped); PC still advances.
REQ-027 ISSUE with opcode==HALT_OP: instr_valid=0, pc_hold=1; next state HALT.
REQ-028 HALT: done=1 and pc_hold=1 held until start=1.
REQ-029 Reserved opcodes (0, 2, 3, 7, 16, 18, 19) SHALL issue with instr_valid=0 and pc_hold=0, acting as NOPs.
REQ-030 Outside ISSUE/ISSUE_MOV, instr_valid, alu_en and movp SHALL be 0; reg_op, reg_src, reg_dst and instr_o SHALL hold their last issued values.
REQ-031 A taken branch or jump changes p at the ISSUE edge; the next FETCH SHALL use the new p with no extra bubble.
REQ-032 PC wrap from 10'h3ff to 0 is owned by the register file; the block SHALL fetch from whatever p presents.

Reset
REQ-033 On an edge with start=1, regardless of state (including mid-mov or mid-fetch), the FSM SHALL go to IDLE, the latency counter and IR SHALL clear to 0, and the outputs SHALL be: pc_hold=1, instr_valid=0, done=0, reg_op=0, reg_src=0, reg_dst=0, instr_o=0, alu_en=0, movp=0.
REQ-034 A start pulse during HALT SHALL clear done on that edge.

Verification
REQ-035 With IMEM_LAT=1, word 9'b01010_0011 at p=0 -> one cycle with instr_valid=1, reg_op=10, reg_src=3, pc_hold=0; 2 cycles per instruction.
REQ-036 With mov words 9'b00110_0000 then 9'b0_0110_1111 -> instr_valid only in ISSUE_MOV, with reg_src=6, reg_dst=15, movp=1; PC advances twice.
REQ-037 HALT_OP word at p=5 -> done=1 and pc_hold=1 held for 20 cycles; start=1 -> done=0 and state IDLE.
REQ-038 With IMEM_LAT=2 -> FETCH lasts 2 cycles and IR equals the data from the second cycle; 3 cycles per instruction.
REQ-039 start=1 asserted in FETCH2 of a mov -> next cycle all outputs are at reset values and no mov is issued after start drops.
REQ-040 Opcodes 28 and 2 back-to-back -> alu_en=1 with instr_valid=1, then instr_valid=0 with pc_hold=0 (NOP).
